// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_drain
// Description : Read-side consumer for an asynchronous FIFO. Pops one word at
//               a time and serializes it into D_SIZE/B_SIZE beats over a
//               valid/ready handshake, back-to-back with no idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
  parameter int D_SIZE    = 16,
  parameter int B_SIZE    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_empty,
  input  logic [D_SIZE-1:0] i_r_data,
  output logic              o_r_inc,
  output logic [B_SIZE-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_word_done
);

  localparam int NUM_BEATS = D_SIZE / B_SIZE;
  localparam int CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(NUM_BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        r_state;
  logic [D_SIZE-1:0] r_word;
  logic [CW-1:0]     r_cnt;
  logic [B_SIZE-1:0] r_data;

  logic [0:0]        w_state_nxt;
  logic [D_SIZE-1:0] w_word_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_beat;
  logic [B_SIZE-1:0] w_data_nxt;
  logic              w_load;
  logic              w_last_acc;

  // State register: FSM state, held word, beat counter and the outgoing beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic: pop/load decisions, beat advance, and next beat select.
  // The next beat is precomputed so o_data can come straight from a register.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_last_acc  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_empty) begin
          w_load = 1'b1;
        end
      end
      S_SEND: begin
        // o_valid is always high in SEND, so i_ready alone means acceptance
        if (i_ready) begin
          if (r_cnt != c_LAST) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_last_acc = 1'b1;
            if (!i_empty) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_word_nxt  = i_r_data;
      w_cnt_nxt   = '0;
      w_state_nxt = S_SEND;
    end

    w_beat     = (MSB_FIRST != 0) ? (c_LAST - w_cnt_nxt) : w_cnt_nxt;
    w_data_nxt = (w_state_nxt == S_SEND) ? w_word_nxt[int'(w_beat)*B_SIZE +: B_SIZE]
                                         : '0;
  end

  // Output logic: the pop strobe and word-done pulse must land in the same
  // cycle the last beat is accepted, so both follow i_ready directly; reset
  // masks them so a discarded word never triggers a pop or a done pulse.
  always_comb begin
    o_r_inc     = w_load & ~RST;
    o_word_done = w_last_acc & ~RST;
    o_valid     = (r_state == S_SEND);
    o_busy      = (r_state == S_SEND);
    o_data      = r_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_drain
// Description : Directed self-checking bench for fifo_rd_drain. Two instances
//               (LSB-first and MSB-first) share one FIFO model and stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ready = 1'b1;
  logic        i_empty;
  logic [15:0] i_r_data;

  logic        inc0, valid0, busy0, done0;
  logic [7:0]  data0;
  logic        inc1, valid1, busy1, done1;
  logic [7:0]  data1;

  // Tiny FIFO model: the bench writes words, LSB-first DUT pops them
  logic [15:0] mem [16];
  int          wr = 0;
  int          rd = 0;

  int total = 0;
  int bad   = 0;

  assign i_empty  = (rd == wr);
  assign i_r_data = mem[rd % 16];

  always #5 clk = ~clk;

  // Pop on the strobe as seen just before the edge
  always @(posedge clk) begin
    if (inc0) rd <= rd + 1;
  end

  fifo_rd_drain #(.D_SIZE(16), .B_SIZE(8), .MSB_FIRST(0)) dut0 (
    .CLK(clk), .RST(rst), .i_empty(i_empty), .i_r_data(i_r_data),
    .o_r_inc(inc0), .o_data(data0), .o_valid(valid0), .i_ready(i_ready),
    .o_busy(busy0), .o_word_done(done0)
  );

  fifo_rd_drain #(.D_SIZE(16), .B_SIZE(8), .MSB_FIRST(1)) dut1 (
    .CLK(clk), .RST(rst), .i_empty(i_empty), .i_r_data(i_r_data),
    .o_r_inc(inc1), .o_data(data1), .o_valid(valid1), .i_ready(i_ready),
    .o_busy(busy1), .o_word_done(done1)
  );

  task automatic push(input logic [15:0] w);
    mem[wr % 16] = w;
    wr = wr + 1;
  endtask

  task automatic test_reset;
    push(16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({inc0, valid0, busy0, done0, data0} !== 12'h000) begin
        bad++;
        $display("FAIL reset_lsb cyc=%0d got=%h exp=000", i, {inc0, valid0, busy0, done0, data0});
      end
      total++;
      if ({inc1, valid1, busy1, done1, data1} !== 12'h000) begin
        bad++;
        $display("FAIL reset_msb cyc=%0d got=%h exp=000", i, {inc1, valid1, busy1, done1, data1});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({inc0, valid0, busy0} !== 3'b100) begin
      bad++;
      $display("FAIL reset_first_pop got=%b exp=100", {inc0, valid0, busy0});
    end
    // Discard the popped word to leave both DUTs idle with an empty FIFO
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({inc0, valid0, i_empty} !== 3'b001) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=001", {inc0, valid0, i_empty});
    end
  endtask

  task automatic test_single;
    logic [3:0] e_inc  = 4'b0001;
    logic [3:0] e_val  = 4'b0110;
    logic [3:0] e_done = 4'b0100;
    logic [7:0] d0 [4];
    logic [7:0] d1 [4];
    d0 = '{8'h00, 8'h5A, 8'hA5, 8'h00};
    d1 = '{8'h00, 8'hA5, 8'h5A, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      i_ready = 1'b1;
      if (i == 0) push(16'hA55A);
      @(negedge clk);
      total++;
      if ({inc0, valid0, busy0, done0, data0} !== {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]}) begin
        bad++;
        $display("FAIL single_lsb cyc=%0d got=%h exp=%h", i, {inc0, valid0, busy0, done0, data0},
                 {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]});
      end
      total++;
      if ({inc1, valid1, busy1, done1, data1} !== {e_inc[i], e_val[i], e_val[i], e_done[i], d1[i]}) begin
        bad++;
        $display("FAIL single_msb cyc=%0d got=%h exp=%h", i, {inc1, valid1, busy1, done1, data1},
                 {e_inc[i], e_val[i], e_val[i], e_done[i], d1[i]});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e_inc  = 8'b0001_0101;
    logic [7:0] e_val  = 8'b0111_1110;
    logic [7:0] e_done = 8'b0101_0100;
    logic [7:0] d0 [8];
    int pops = 0;
    d0 = '{8'h00, 8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      i_ready = 1'b1;
      if (i == 0) begin
        push(16'h1122);
        push(16'h3344);
        push(16'h5566);
      end
      @(negedge clk);
      if (inc0) pops++;
      total++;
      if ({inc0, valid0, busy0, done0, data0} !== {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]}) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, {inc0, valid0, busy0, done0, data0},
                 {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]});
      end
    end
    total++;
    if (pops != 3) begin
      bad++;
      $display("FAIL b2b_pops got=%0d exp=3", pops);
    end
  endtask

  task automatic test_backpressure;
    logic [10:0] e_rdy  = 11'b111_1000_0011;
    logic [10:0] e_inc  = 11'b000_1000_0001;
    logic [10:0] e_val  = 11'b011_1111_1110;
    logic [10:0] e_done = 11'b010_1000_0000;
    logic [7:0]  d0 [11];
    logic [7:0]  d1 [11];
    d0 = '{8'h00, 8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h88, 8'h77, 8'h00};
    d1 = '{8'h00, 8'hC3, 8'hD4, 8'hD4, 8'hD4, 8'hD4, 8'hD4, 8'hD4, 8'h77, 8'h88, 8'h00};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      i_ready = e_rdy[i];
      if (i == 0) push(16'hC3D4);
      if (i == 2) push(16'h7788);
      @(negedge clk);
      total++;
      if ({inc0, valid0, busy0, done0, data0} !== {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]}) begin
        bad++;
        $display("FAIL bp_lsb cyc=%0d got=%h exp=%h", i, {inc0, valid0, busy0, done0, data0},
                 {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]});
      end
      total++;
      if ({valid1, data1} !== {e_val[i], d1[i]}) begin
        bad++;
        $display("FAIL bp_msb cyc=%0d got=%h exp=%h", i, {valid1, data1}, {e_val[i], d1[i]});
      end
    end
  endtask

  task automatic test_reset_midword;
    logic [6:0] e_rst  = 7'b000_0100;
    logic [6:0] e_inc  = 7'b000_1001;
    logic [6:0] e_val  = 7'b011_0110;
    logic [6:0] e_done = 7'b010_0000;
    logic [7:0] d0 [7];
    logic [7:0] d1 [7];
    d0 = '{8'h00, 8'hF2, 8'hE1, 8'h00, 8'h0B, 8'h0A, 8'h00};
    d1 = '{8'h00, 8'hE1, 8'hF2, 8'h00, 8'h0A, 8'h0B, 8'h00};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      i_ready = 1'b1;
      rst = e_rst[i];
      if (i == 0) begin
        push(16'hE1F2);
        push(16'h0A0B);
      end
      @(negedge clk);
      total++;
      if ({inc0, valid0, busy0, done0, data0} !== {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]}) begin
        bad++;
        $display("FAIL rstmid_lsb cyc=%0d got=%h exp=%h", i, {inc0, valid0, busy0, done0, data0},
                 {e_inc[i], e_val[i], e_val[i], e_done[i], d0[i]});
      end
      total++;
      if ({inc1, valid1, done1, data1} !== {e_inc[i], e_val[i], e_done[i], d1[i]}) begin
        bad++;
        $display("FAIL rstmid_msb cyc=%0d got=%h exp=%h", i, {inc1, valid1, done1, data1},
                 {e_inc[i], e_val[i], e_done[i], d1[i]});
      end
    end
    total++;
    if (rd != wr) begin
      bad++;
      $display("FAIL rstmid_fifo_level got=%0d exp=0", wr - rd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side consumer for the system's asynchronous FIFO. Runs in the read clock domain: watches the FIFO empty flag, pops one word at a time, and serializes each D_SIZE-bit word into D_SIZE/B_SIZE beats. Beats go to a downstream byte-wide sink, such as the UART transmitter, over a valid/ready handshake. Supports back-to-back words with no idle cycle, so the sink sees a continuous stream while the FIFO holds data.

## Interface
- D_SIZE, 16, FIFO word width; must be an integer multiple of B_SIZE
- B_SIZE, 8, beat width presented to the sink
- MSB_FIRST, 0, 0 = least-significant beat first, 1 = most-significant beat first
- CLK  in  1  read-domain clock; same clock as the FIFO read port
- RST  in  1  synchronous, active-high reset
- i_empty  in  1  FIFO empty flag, registered in the CLK domain
- i_r_data  in  D_SIZE  FIFO read data; valid whenever i_empty=0
- o_r_inc  out  1  FIFO pop strobe, one CLK cycle per word
- o_data  out  B_SIZE  current beat
- o_valid  out  1  beat valid
- i_ready  in  1  sink accepts the beat when o_valid & i_ready
- o_busy  out  1  high while a word is held (state SEND)
- o_word_done  out  1  one-cycle pulse on acceptance of the last beat of a word

## Operation
- NUM_BEATS = D_SIZE/B_SIZE; beat counter width = max(1, clog2(NUM_BEATS)).
- Internal state: word register (D_SIZE), beat counter, state bit.
- FSM states:
  - IDLE:
    - if i_empty=0: load i_r_data into the word register, assert o_r_inc combinationally this cycle, clear the beat counter, go to SEND.
    - else stay in IDLE.
  - SEND:
    - o_valid=1.
    - o_data = word[(k+1)*B_SIZE-1 : k*B_SIZE], where k = beat counter (MSB_FIRST=0) or NUM_BEATS-1-beat counter (MSB_FIRST=1).
    - On o_valid & i_ready with counter < NUM_BEATS-1: increment the counter.
    - On o_valid & i_ready with counter = NUM_BEATS-1: pulse o_word_done. Then:
      - if i_empty=0: load the next word, assert o_r_inc this cycle, clear the counter, stay in SEND.
      - else go to IDLE.
- o_r_inc is asserted only when i_empty=0, and never in two consecutive cycles unless NUM_BEATS=1.
- o_data and o_valid stay stable while o_valid=1 and i_ready=0; i_ready may toggle arbitrarily.
- o_data is 0 whenever o_valid=0.
- Reset (any state, any cycle): state=IDLE, counter=0, word=0. No o_r_inc in the reset cycle. A word held mid-transfer is discarded; it was already popped and is not re-read.

## Timing
- Reset values: o_r_inc=0, o_valid=0, o_data=0, o_busy=0, o_word_done=0.
- Pop-to-first-beat latency: o_r_inc in cycle N (IDLE), o_valid=1 with beat 0 in cycle N+1.
- Steady-state throughput with i_ready held high: one beat per cycle, including across word boundaries.
- o_r_inc for the next word coincides with the o_word_done cycle.
- i_empty is sampled only in the cycle o_r_inc could be raised. The FIFO guarantees i_empty reflects the post-pop pointer by the following cycle. For NUM_BEATS=1 this gives one pop per cycle at most.
- o_busy = (state==SEND), registered.
- All outputs except o_r_inc are driven from registers. o_r_inc is combinational from state, i_empty, i_ready and counter.

## Test plan
- Reset: hold RST=1 for 3 cycles with i_empty=0 -> o_r_inc, o_valid, o_data, o_busy, o_word_done all 0 throughout; first o_r_inc in the first cycle after RST falls.
- Single word, D_SIZE=16, B_SIZE=8, MSB_FIRST=0, i_r_data=16'hA55A, i_ready=1, i_empty drops to 1 after the pop:
  - o_r_inc for 1 cycle.
  - Next cycles: beats 8'h5A then 8'hA5.
  - o_word_done on the 8'hA5 cycle, then IDLE with o_valid=0.
- Same stimulus with MSB_FIRST=1 -> beats 8'hA5 then 8'h5A.
- Back-to-back: three words 16'h1122, 16'h3344, 16'h5566 available, i_ready=1:
  - Six consecutive valid beats 22,11,44,33,66,55 with no gap.
  - Exactly three o_r_inc pulses, each coincident with o_word_done of the prior word (the first from IDLE).
- Backpressure: i_ready=0 for 5 cycles mid-word -> o_data and o_valid frozen, counter held, no o_r_inc; transfer resumes on i_ready=1.
- Reset mid-word: RST after beat 0 accepted -> next cycle o_valid=0, no second beat, no extra pop. After release with i_empty=0, a fresh word is popped and sent from beat 0.
